// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner:
// segment patterns, scan state encoding and a width helper.
package seven_segment_scanner_pkg;

    typedef enum logic {
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    // Active-low patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Bits needed to hold values 0..value-1, never less than one
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_bcd_to_seven_segment.sv
// Combinational BCD to active-low seven-segment decoder;
// non-decimal codes show a dash.
module bcd_to_seven_segment
    import seven_segment_scanner_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] segments
);

    always_comb begin
        case (bcd)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes a packed BCD word onto a common-anode display with
// blank gaps between digits, per-scan snapshot, zero blanking and blink.
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int NUMBER_OF_DIGITS            = 4,
    parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
    parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int DIGIT_REFRESH_RATE_IN_HZ    = 1000,
    parameter int BLANK_CYCLES                = 64,
    parameter int BLINK_RATE_IN_HZ            = 2,
    parameter int DOT_POSITION                = 2,
    parameter int LEADING_ZERO_BLANK          = 1
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 enable,
    input  logic                                                 blink,
    input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
    output logic [6:0]                                           segments,
    output logic                                                 dot,
    output logic [NUMBER_OF_DIGITS-1:0]                          digit_select,
    output logic [clog2_min1(NUMBER_OF_DIGITS)-1:0]              digit_index
);

    localparam int TICKS        = BOARD_CLOCK_FREQUENCY_IN_HZ / (DIGIT_REFRESH_RATE_IN_HZ * NUMBER_OF_DIGITS);
    localparam int BLINK_PERIOD = BOARD_CLOCK_FREQUENCY_IN_HZ / BLINK_RATE_IN_HZ;
    localparam int BLINK_HALF   = BLINK_PERIOD / 2;
    localparam int SLOT_W       = clog2_min1(TICKS);
    localparam int BLINK_W      = clog2_min1(BLINK_PERIOD);
    localparam int INDEX_W      = clog2_min1(NUMBER_OF_DIGITS);
    localparam int NUMBER_W     = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
    localparam int BPD          = NUMBER_OF_BITS_PER_DIGIT;

    scan_state_t                   state;
    scan_state_t                   state_next;
    logic [SLOT_W-1:0]             slot_count;
    logic [SLOT_W-1:0]             slot_next;
    logic [INDEX_W-1:0]            index_next;
    logic [NUMBER_W-1:0]           shadow;
    logic [NUMBER_W-1:0]           shadow_next;
    logic [BLINK_W-1:0]            blink_count;
    logic [BLINK_W-1:0]            blink_next;
    logic                          load_pending;
    logic                          slot_end;
    logic                          show_digit;
    logic                          zeros_above;
    logic [NUMBER_OF_DIGITS-1:0]   lz_mask;
    logic [3:0]                    digit_value;
    logic [6:0]                    decoded;

    // Next-state values; outputs are registered from these so that the
    // visible pattern always matches the registered scan position.
    always_comb begin
        slot_end   = (slot_count == SLOT_W'(TICKS - 1));
        slot_next  = slot_end ? '0 : slot_count + 1'b1;
        state_next = state;
        index_next = digit_index;
        case (state)
            SCAN_BLANK: begin
                if (slot_count == SLOT_W'(BLANK_CYCLES - 1)) begin
                    state_next = SCAN_DRIVE;
                end
            end
            SCAN_DRIVE: begin
                if (slot_end) begin
                    state_next = SCAN_BLANK;
                    index_next = (digit_index == INDEX_W'(NUMBER_OF_DIGITS - 1)) ? '0 : digit_index + 1'b1;
                end
            end
            default: state_next = SCAN_BLANK;
        endcase
        shadow_next = (load_pending || (state == SCAN_DRIVE && slot_end &&
                       digit_index == INDEX_W'(NUMBER_OF_DIGITS - 1))) ? number : shadow;
        blink_next  = (blink_count == BLINK_W'(BLINK_PERIOD - 1)) ? '0 : blink_count + 1'b1;
        show_digit  = enable && !(blink && (blink_next >= BLINK_W'(BLINK_HALF))) &&
                      (state_next == SCAN_DRIVE);
    end

    // Digit mux plus leading-zero mask, scanning from the most significant digit down
    always_comb begin
        digit_value = '0;
        lz_mask     = '0;
        zeros_above = 1'b1;
        for (int i = NUMBER_OF_DIGITS - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (shadow_next[i*BPD +: BPD] == '0);
            if (LEADING_ZERO_BLANK != 0 && i > DOT_POSITION) begin
                lz_mask[i] = zeros_above;
            end
            if (index_next == INDEX_W'(i)) begin
                digit_value = 4'(shadow_next[i*BPD +: BPD]);
            end
        end
    end

    bcd_to_seven_segment u_decoder (
        .bcd      (digit_value),
        .segments (decoded)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= SCAN_BLANK;
            slot_count   <= '0;
            digit_index  <= '0;
            shadow       <= '0;
            blink_count  <= '0;
            load_pending <= 1'b1;
            segments     <= SEG_OFF;
            dot          <= 1'b1;
            digit_select <= '1;
        end else begin
            state        <= state_next;
            slot_count   <= slot_next;
            digit_index  <= index_next;
            shadow       <= shadow_next;
            blink_count  <= blink_next;
            load_pending <= 1'b0;
            if (show_digit) begin
                segments     <= lz_mask[index_next] ? SEG_OFF : decoded;
                dot          <= (index_next != INDEX_W'(DOT_POSITION));
                digit_select <= ~(NUMBER_OF_DIGITS'(1) << index_next);
            end else begin
                segments     <= SEG_OFF;
                dot          <= 1'b1;
                digit_select <= '1;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus
// randomized traffic compared against a time-based reference model.
module tb_seven_segment_scanner;

    localparam int NUM_DIGITS   = 4;
    localparam int BITS         = 4;
    localparam int CLK_HZ       = 1600;
    localparam int REFRESH_HZ   = 100;
    localparam int BLANK_CYC    = 1;
    localparam int BLINK_HZ     = 10;
    localparam int DOT_POS      = 2;
    localparam int LZB          = 1;
    localparam int SLOT         = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int SCAN         = SLOT * NUM_DIGITS;
    localparam int BLINK_PERIOD = CLK_HZ / BLINK_HZ;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        enable = 1'b0;
    logic        blink  = 1'b0;
    logic [15:0] number = '0;
    logic [6:0]  segments;
    logic        dot;
    logic [3:0]  digit_select;
    logic [1:0]  digit_index;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          edges        = 0;
    logic [15:0] model_shadow = '0;
    logic [6:0]  seg_table [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                    7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seven_segment_scanner #(
        .NUMBER_OF_DIGITS            (NUM_DIGITS),
        .NUMBER_OF_BITS_PER_DIGIT    (BITS),
        .BOARD_CLOCK_FREQUENCY_IN_HZ (CLK_HZ),
        .DIGIT_REFRESH_RATE_IN_HZ    (REFRESH_HZ),
        .BLANK_CYCLES                (BLANK_CYC),
        .BLINK_RATE_IN_HZ            (BLINK_HZ),
        .DOT_POSITION                (DOT_POS),
        .LEADING_ZERO_BLANK          (LZB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .blink        (blink),
        .number       (number),
        .segments     (segments),
        .dot          (dot),
        .digit_select (digit_select),
        .digit_index  (digit_index)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h at edge %0d", tag, observed, expected, edges);
        end
    endtask

    // Expected display after 'edges' clocks since reset release
    task automatic checkOutput(input string tag);
        int         p;
        int         d;
        bit         on;
        bit         lead_zero;
        logic [3:0] val;
        logic [6:0] exp_seg;
        logic       exp_dot;
        logic [3:0] exp_sel;
        p       = edges % SLOT;
        d       = (edges / SLOT) % NUM_DIGITS;
        on      = enable && !(blink && (edges % BLINK_PERIOD) >= BLINK_PERIOD / 2) && (p >= BLANK_CYC);
        exp_seg = 7'h7F;
        exp_dot = 1'b1;
        exp_sel = 4'hF;
        if (on) begin
            val       = model_shadow[d*BITS +: BITS];
            exp_seg   = (val > 9) ? 7'h3F : seg_table[int'(val)];
            lead_zero = (LZB != 0) && (d > DOT_POS);
            for (int j = d; j < NUM_DIGITS; j++) begin
                if (model_shadow[j*BITS +: BITS] != 4'h0) lead_zero = 1'b0;
            end
            if (lead_zero) exp_seg = 7'h7F;
            exp_dot = (d == DOT_POS) ? 1'b0 : 1'b1;
            exp_sel = ~(4'b0001 << d);
        end
        checkValue({tag, ".segments"}, {1'b0, segments}, {1'b0, exp_seg});
        checkValue({tag, ".dot"}, {7'b0, dot}, {7'b0, exp_dot});
        checkValue({tag, ".digit_select"}, {4'b0, digit_select}, {4'b0, exp_sel});
        checkValue({tag, ".digit_index"}, {6'b0, digit_index}, 8'(d));
    endtask

    task automatic applyStimulus(input logic [15:0] new_number, input logic new_enable, input logic new_blink);
        number = new_number;
        enable = new_enable;
        blink  = new_blink;
    endtask

    // The display snapshots the input once after reset and whenever a new scan begins
    task automatic runCycles(input int count, input string tag);
        repeat (count) begin
            @(posedge clk);
            edges++;
            if (edges == 1 || edges % SCAN == 0) model_shadow = number;
            #1;
            checkOutput(tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(16'h1234, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        edges = 0;
        checkOutput("reset");
        #2 rst = 1'b0;

        runCycles(1, "scan");
        checkValue("first_drive_seg", {1'b0, segments}, 8'h19);
        checkValue("first_drive_sel", {4'b0, digit_select}, 8'h0E);
        runCycles(SCAN * 2 - 1, "scan");

        runCycles(SLOT + 1, "snapshot");
        applyStimulus(16'h0559, 1'b1, 1'b0);
        runCycles(SCAN * 2, "snapshot");

        applyStimulus(16'h00A0, 1'b1, 1'b0);
        runCycles(SCAN * 2, "non_bcd");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) number = 16'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            if (n % 40 == 0) blink = 1'($urandom_range(0, 1));
            runCycles(1, "random");
        end

        applyStimulus(16'h4321, 1'b0, 1'b0);
        runCycles(1, "disable");
        checkValue("disable_sel", {4'b0, digit_select}, 8'h0F);
        runCycles(20, "disable");

        applyStimulus(16'h1234, 1'b1, 1'b1);
        runCycles(BLINK_PERIOD * 2 + 80, "blink");

        applyStimulus(16'h1234, 1'b1, 1'b0);
        for (int n = 0; n < 64; n++) begin
            if ((edges / SLOT) % NUM_DIGITS == 2 && edges % SLOT == BLANK_CYC) break;
            runCycles(1, "seek_digit2");
        end
        checkValue("pre_reset_index", {6'b0, digit_index}, 8'd2);
        checkValue("pre_reset_sel", {4'b0, digit_select}, 8'h0B);
        #2 rst = 1'b1;
        #1;
        edges        = 0;
        model_shadow = '0;
        checkOutput("async_reset");
        checkValue("async_reset_sel", {4'b0, digit_select}, 8'h0F);
        #1 rst = 1'b0;
        runCycles(SCAN * 2 + 8, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
